// File: rtl/inst_fetch.sv
// Instruction fetch stage: one-entry instruction register in front of decode,
// sequential PC advance, beq redirect with a one-cycle bubble.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_addr,
    input  logic        id_ready,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    output logic [15:0] fetch_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      r_state;
    logic [29:0] r_pc_w;
    logic [31:0] r_ir;
    logic [29:0] r_ir_pc_w;
    logic [15:0] r_fetch_cnt;

    logic [29:0] w_seq_w;
    logic [29:0] w_br_target_w;

    // PCs are held as word addresses so the low two bits are structurally zero
    // and all arithmetic wraps modulo 2^32 on the byte address.
    assign w_seq_w       = r_pc_w + 30'd1;
    assign w_br_target_w = r_ir_pc_w + 30'd1 + {{14{br_offset[15]}}, br_offset};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_pc_w      <= RESET_PC[31:2];
            r_ir        <= '0;
            r_ir_pc_w   <= '0;
            r_fetch_cnt <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    r_ir      <= inst_in;
                    r_ir_pc_w <= r_pc_w;
                    r_pc_w    <= w_seq_w;
                    r_state   <= FULL;
                end
                FULL: begin
                    if (br_taken) begin
                        r_pc_w  <= w_br_target_w;
                        r_state <= EMPTY;
                    end else if (id_ready) begin
                        r_ir      <= inst_in;
                        r_ir_pc_w <= r_pc_w;
                        r_pc_w    <= w_seq_w;
                        r_state   <= FULL;
                        if (r_fetch_cnt != '1)
                            r_fetch_cnt <= r_fetch_cnt + 16'd1;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign pc_addr   = {r_pc_w, 2'b00};
    assign ir        = r_ir;
    assign ir_pc     = {r_ir_pc_w, 2'b00};
    assign ir_valid  = r_state;
    assign fetch_cnt = r_fetch_cnt;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, 32'h0000_0000, word-aligned address loaded into the PC on reset.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 inst_in  input  32  instruction word returned combinationally by instruction memory for pc_addr.
REQ-006 pc_addr  output  32  current fetch PC; drives instruction-memory address.
REQ-007 id_ready  input  1  decode stage accepts ir this cycle.
REQ-008 br_taken  input  1  decode resolved the instruction in ir as a taken branch (beq).
REQ-009 br_offset  input  16  signed word offset (beq immediate) of the instruction in ir.
REQ-010 ir  output  32  instruction register presented to decode.
REQ-011 ir_pc  output  32  address the instruction in ir was fetched from.
REQ-012 ir_valid  output  1  ir holds a valid instruction.
REQ-013 fetch_cnt  output  16  count of instructions handed to decode.

Function
REQ-014 State SHALL be EMPTY (ir_valid=0) or FULL (ir_valid=1); ir_valid equals the state bit.
REQ-015 Redirect: when FULL and br_taken=1, next cycle pc_addr = ir_pc + 4 + (sign_extend(br_offset) << 2), ir_valid = 0 (flush), ir/ir_pc unchanged; id_ready ignored that cycle.
REQ-016 br_taken while EMPTY SHALL be ignored.
REQ-017 Load: when no redirect and (EMPTY or id_ready=1), SHALL latch ir <= inst_in, ir_pc <= pc_addr, ir_valid <= 1, pc_addr <= pc_addr + 4.
REQ-018 Hold: when FULL, id_ready=0, br_taken=0, SHALL hold pc_addr, ir, ir_pc, ir_valid.
REQ-019 Latency: instruction at pc_addr appears on ir one cycle after pc_addr is presented; steady-state throughput one instruction per cycle with id_ready=1.
REQ-020 Branch penalty SHALL be exactly one bubble cycle (ir_valid=0) after a redirect.
REQ-021 All PC arithmetic SHALL be 32-bit modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000); pc_addr[1:0] SHALL always be 00.
REQ-022 fetch_cnt SHALL increment by 1 on each cycle with ir_valid=1, id_ready=1, br_taken=0; saturate at 16'hFFFF.
REQ-023 Outputs SHALL be registered; pc_addr SHALL have no combinational path from any input.

Reset
REQ-024 On rst=1, immediately and independent of clk: pc_addr=RESET_PC, ir=0, ir_pc=0, ir_valid=0, fetch_cnt=0, state EMPTY.
REQ-025 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation; first rising edge after deassertion performs a Load from RESET_PC.

Verification
REQ-026 Reset then id_ready=1 held, memory returns word at pc_addr -> pc_addr 0,4,8,...; ir_pc lags pc_addr by one cycle; ir at ir_pc=0x04 equals 32'h3c011234; fetch_cnt increments each cycle from the second edge.
REQ-027 FULL with ir_pc=0x30, br_taken=1, br_offset=16'hFFFB -> next cycle pc_addr=0x20, ir_valid=0; following cycle ir_pc=0x20, ir_valid=1; fetch_cnt unchanged during redirect.
REQ-028 FULL with ir_pc=0x2C, br_offset=0: br_taken=0 -> sequential pc_addr 0x34; br_taken=1 -> pc_addr=0x30.
REQ-029 id_ready=0 for 3 cycles while FULL at ir_pc=0x08 -> pc_addr, ir, ir_pc stable 3 cycles, fetch_cnt frozen; release -> ir_pc=0x0C next cycle.
REQ-030 RESET_PC=32'hFFFF_FFFC, id_ready=1 -> pc_addr 0xFFFF_FFFC then 0x0000_0000 then 0x0000_0004.
REQ-031 rst pulsed between clock edges while stalled FULL -> outputs reach reset values before next edge; no Load occurs until after deassertion.
